// File: rtl/crc_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check_pkg
//  Description : Shared width limits and bit helpers for the CRC checker.
//  Revision    : 1.0  initial release
// ============================================================================
package crc_check_pkg;

   localparam int MAX_W  = 64;
   localparam int POLY_W = MAX_W + 1;

   function automatic int poly_degree(input logic [POLY_W-1:0] poly);
      int deg;
      deg = 0;
      for (int i = 0; i < POLY_W; i++) begin
         if (poly[i]) deg = i;
      end
      return deg;
   endfunction

   function automatic logic [MAX_W-1:0] deg_mask(input int deg);
      logic [MAX_W-1:0] m;
      for (int i = 0; i < MAX_W; i++) begin
         m[i] = (i < deg);
      end
      return m;
   endfunction

   // Reverses the low w bits of x; x must already be masked to w bits.
   function automatic logic [MAX_W-1:0] rev_bits(input logic [MAX_W-1:0] x, input int w);
      logic [MAX_W-1:0] r;
      for (int i = 0; i < MAX_W; i++) begin
         r[i] = x[MAX_W-1-i];
      end
      return r >> (MAX_W - w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc_check_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check_lfsr
//  Description : Combinational MSB-first CRC update of one word, variable degree.
//  Revision    : 1.0  initial release
// ============================================================================
module crc_check_lfsr
   import crc_check_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int POLY_WIDTH = 32
) (
   input  logic [POLY_WIDTH-1:0] state_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [POLY_WIDTH:0]   poly_i,
   output logic [POLY_WIDTH-1:0] state_o
);

   logic [POLY_WIDTH-1:0] w_mask;
   logic [POLY_WIDTH-1:0] w_top;
   logic [POLY_WIDTH-1:0] w_taps;
   logic [POLY_WIDTH-1:0] w_s;

   always_comb begin
      w_mask = POLY_WIDTH'(deg_mask(poly_degree(POLY_W'(poly_i))));
      // One-hot at bit deg-1: the feedback tap for the active degree.
      w_top  = w_mask & ~(w_mask >> 1);
      w_taps = poly_i[POLY_WIDTH-1:0] & w_mask;
      w_s    = state_i & w_mask;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if ((|(w_s & w_top)) ^ data_i[i]) begin
            w_s = ((w_s << 1) & w_mask) ^ w_taps;
         end else begin
            w_s = (w_s << 1) & w_mask;
         end
      end
      state_o = w_s;
   end

endmodule
`default_nettype wire

// File: rtl/crc_check.sv
`default_nettype none
// ============================================================================
//  Module      : crc_check
//  Description : Receive-side CRC checker; strips the trailing CRC word and
//                reports a per-frame status strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module crc_check
   import crc_check_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CRC_WIDTH-1:0]  init_in,
   input  logic [CRC_WIDTH:0]    poly_in,
   input  logic                  data_reverse,
   input  logic                  crc_reverse,
   input  logic [CRC_WIDTH-1:0]  xorout_in,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  st_valid,
   output logic                  st_ok,
   output logic [CRC_WIDTH-1:0]  st_crc,
   output logic [LEN_WIDTH-1:0]  st_len
);

   if (CRC_WIDTH > DATA_WIDTH || CRC_WIDTH > MAX_W) begin : g_width_check
      $error("crc_check: CRC_WIDTH must not exceed DATA_WIDTH or MAX_W");
   end

   logic [CRC_WIDTH-1:0]  cfg_init_q, cfg_init_d, cfg_xor_q, cfg_xor_d;
   logic [CRC_WIDTH:0]    cfg_poly_q, cfg_poly_d;
   logic                  cfg_drev_q, cfg_drev_d, cfg_crev_q, cfg_crev_d;
   logic                  in_frame_q, in_frame_d, hold_vld_q, hold_vld_d;
   logic [CRC_WIDTH-1:0]  state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d, m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic                  st_valid_q, st_valid_d, st_ok_q, st_ok_d;
   logic [CRC_WIDTH-1:0]  st_crc_q, st_crc_d;
   logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;

   logic                  w_accept;
   logic [CRC_WIDTH-1:0]  w_cur_state, w_cur_xor, w_mask, w_state_m, w_calc, w_lfsr_next;
   logic [CRC_WIDTH:0]    w_cur_poly;
   logic                  w_cur_drev, w_cur_crev, w_ok;
   logic [DATA_WIDTH-1:0] w_data_rev, w_lfsr_data;
   int                    w_deg;

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_rev
      assign w_data_rev[gi] = s_data[DATA_WIDTH-1-gi];
   end

   assign s_ready  = !reset && (!m_valid_q || m_ready);
   assign w_accept = s_valid && s_ready;

   // The first word of a frame runs on the live config; later words on the latched copy.
   always_comb begin
      w_cur_state = in_frame_q ? state_q    : init_in;
      w_cur_poly  = in_frame_q ? cfg_poly_q : poly_in;
      w_cur_drev  = in_frame_q ? cfg_drev_q : data_reverse;
      w_cur_crev  = in_frame_q ? cfg_crev_q : crc_reverse;
      w_cur_xor   = in_frame_q ? cfg_xor_q  : xorout_in;
      w_deg       = poly_degree(POLY_W'(w_cur_poly));
      w_mask      = CRC_WIDTH'(deg_mask(w_deg));
      w_state_m   = w_cur_state & w_mask;
      w_lfsr_data = w_cur_drev ? w_data_rev : s_data;
      w_calc      = ((w_cur_crev ? CRC_WIDTH'(rev_bits(MAX_W'(w_state_m), w_deg)) : w_state_m)
                     ^ w_cur_xor) & w_mask;
      w_ok        = (w_calc == (s_data[CRC_WIDTH-1:0] & w_mask));
   end

   crc_check_lfsr #(
      .DATA_WIDTH (DATA_WIDTH),
      .POLY_WIDTH (CRC_WIDTH)
   ) u_lfsr (
      .state_i (w_cur_state),
      .data_i  (w_lfsr_data),
      .poly_i  (w_cur_poly),
      .state_o (w_lfsr_next)
   );

   always_comb begin
      cfg_init_d = cfg_init_q;
      cfg_poly_d = cfg_poly_q;
      cfg_drev_d = cfg_drev_q;
      cfg_crev_d = cfg_crev_q;
      cfg_xor_d  = cfg_xor_q;
      in_frame_d = in_frame_q;
      hold_vld_d = hold_vld_q;
      state_d    = state_q;
      len_d      = len_q;
      hold_d     = hold_q;
      m_data_d   = m_data_q;
      m_last_d   = m_last_q;
      m_valid_d  = m_valid_q && !m_ready;
      st_valid_d = 1'b0;
      st_ok_d    = st_ok_q;
      st_crc_d   = st_crc_q;
      st_len_d   = st_len_q;
      if (w_accept) begin
         if (!in_frame_q) begin
            cfg_init_d = init_in;
            cfg_poly_d = poly_in;
            cfg_drev_d = data_reverse;
            cfg_crev_d = crc_reverse;
            cfg_xor_d  = xorout_in;
         end
         if (hold_vld_q) begin
            m_data_d  = hold_q;
            m_last_d  = s_last;
            m_valid_d = 1'b1;
         end
         if (!s_last) begin
            state_d    = w_lfsr_next;
            len_d      = (len_q == '1) ? len_q : len_q + 1'b1;
            hold_d     = s_data;
            hold_vld_d = 1'b1;
            in_frame_d = 1'b1;
         end else begin
            st_valid_d = 1'b1;
            st_ok_d    = w_ok;
            st_crc_d   = w_calc;
            st_len_d   = len_q;
            state_d    = '0;
            len_d      = '0;
            hold_vld_d = 1'b0;
            in_frame_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_init_q <= '0;
         cfg_poly_q <= '0;
         cfg_drev_q <= 1'b0;
         cfg_crev_q <= 1'b0;
         cfg_xor_q  <= '0;
         in_frame_q <= 1'b0;
         hold_vld_q <= 1'b0;
         state_q    <= '0;
         len_q      <= '0;
         hold_q     <= '0;
         m_data_q   <= '0;
         m_last_q   <= 1'b0;
         m_valid_q  <= 1'b0;
         st_valid_q <= 1'b0;
         st_ok_q    <= 1'b0;
         st_crc_q   <= '0;
         st_len_q   <= '0;
      end else begin
         cfg_init_q <= cfg_init_d;
         cfg_poly_q <= cfg_poly_d;
         cfg_drev_q <= cfg_drev_d;
         cfg_crev_q <= cfg_crev_d;
         cfg_xor_q  <= cfg_xor_d;
         in_frame_q <= in_frame_d;
         hold_vld_q <= hold_vld_d;
         state_q    <= state_d;
         len_q      <= len_d;
         hold_q     <= hold_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
         m_valid_q  <= m_valid_d;
         st_valid_q <= st_valid_d;
         st_ok_q    <= st_ok_d;
         st_crc_q   <= st_crc_d;
         st_len_q   <= st_len_d;
      end
   end

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign st_valid = st_valid_q;
   assign st_ok    = st_ok_q;
   assign st_crc   = st_crc_q;
   assign st_len   = st_len_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_check
//  Description : Self-checking bench for crc_check (8-bit data, 8-bit CRC).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crc_check;

   localparam int DW = 8;
   localparam int CW = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] init_in = '0;
   logic [CW:0]   poly_in = 9'h107;
   logic          data_reverse = 1'b0;
   logic          crc_reverse = 1'b0;
   logic [CW-1:0] xorout_in = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready = 1'b1;
   logic          st_valid;
   logic          st_ok;
   logic [CW-1:0] st_crc;
   logic [LW-1:0] st_len;

   always #5 clk = ~clk;

   crc_check #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .init_in(init_in), .poly_in(poly_in),
      .data_reverse(data_reverse), .crc_reverse(crc_reverse), .xorout_in(xorout_in),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .st_valid(st_valid), .st_ok(st_ok), .st_crc(st_crc), .st_len(st_len)
   );

   typedef struct {
      logic [8:0]   poly;
      logic [7:0]   init;
      bit           drev;
      bit           crev;
      logic [7:0]   xo;
      int           n;
      logic [127:0] pl;
      logic [7:0]   crc;
      bit           ok;
      logic [7:0]   scrc;
   } vec_t;

   typedef struct packed {
      logic        ok;
      logic [7:0]  crc;
      logic [15:0] len;
   } st_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         rdy_rand = 1'b0;
   logic [8:0] exp_beats[$];
   st_t        exp_st[$];
   vec_t       vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // Byte-at-a-time textbook CRC-8 (degree-8 polynomials only).
   function automatic logic [7:0] ref_crc(input vec_t v);
      logic [7:0] c;
      logic [7:0] d;
      c = v.init;
      for (int i = 0; i < v.n; i++) begin
         d = v.pl[(v.n-1-i)*8 +: 8];
         if (v.drev) d = rev8(d);
         c = c ^ d;
         for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ v.poly[7:0]) : (c << 1);
      end
      if (v.crev) c = rev8(c);
      return c ^ v.xo;
   endfunction

   always @(posedge clk) begin
      #1;
      m_ready = rdy_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   logic       stalled = 1'b0;
   logic [8:0] prev_out = '0;
   always @(negedge clk) begin
      if (reset) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", {m_last, m_data}, prev_out);
         end
         chk("s_ready", s_ready, !(m_valid && !m_ready));
         if (m_valid && m_ready) begin
            if (exp_beats.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL beat_extra: got %0h, expected no beat (t=%0t)", {m_last, m_data}, $time);
            end else begin
               chk("beat", {m_last, m_data}, exp_beats.pop_front());
            end
         end
         if (st_valid) begin
            if (exp_st.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL status_extra: got strobe, expected none (t=%0t)", $time);
            end else begin
               st_t e;
               e = exp_st.pop_front();
               chk("st_ok", st_ok, e.ok);
               chk("st_crc", st_crc, e.crc);
               chk("st_len", st_len, e.len);
            end
         end
         stalled  = m_valid && !m_ready;
         prev_out = {m_last, m_data};
      end
   end

   task automatic put(input logic [7:0] d, input bit l, input bit gaps);
      int t;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_data = d; s_last = l; s_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: s_ready stuck at 0, expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic scramble_cfg();
      poly_in = 9'($urandom); init_in = 8'($urandom); xorout_in = 8'($urandom);
      data_reverse = 1'($urandom); crc_reverse = 1'($urandom);
   endtask

   task automatic send_vec(input vec_t v, input bit gaps);
      st_t s;
      for (int i = 0; i < v.n; i++) exp_beats.push_back({(i == v.n - 1), v.pl[(v.n-1-i)*8 +: 8]});
      s.ok = v.ok; s.crc = v.scrc; s.len = 16'(v.n);
      exp_st.push_back(s);
      poly_in = v.poly; init_in = v.init; xorout_in = v.xo;
      data_reverse = v.drev; crc_reverse = v.crev;
      for (int i = 0; i < v.n; i++) begin
         put(v.pl[(v.n-1-i)*8 +: 8], 1'b0, gaps);
         if (i == 0) scramble_cfg();
      end
      put(v.crc, 1'b1, gaps);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_beats.size() != 0 || exp_st.size() != 0) && t < 400) begin
         @(posedge clk); t++;
      end
      #1;
      if (exp_beats.size() != 0 || exp_st.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d beats and %0d statuses still outstanding, expected 0",
                  exp_beats.size(), exp_st.size());
         exp_beats.delete(); exp_st.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vt[0] = '{9'h107, 8'h00, 1'b0, 1'b0, 8'h00, 9, 128'h313233343536373839, 8'hF4, 1'b1, 8'hF4};
      vt[1] = '{9'h107, 8'h00, 1'b0, 1'b0, 8'h00, 9, 128'h313233343536373839, 8'hF5, 1'b0, 8'hF4};
      vt[2] = '{9'h131, 8'h00, 1'b1, 1'b1, 8'h00, 9, 128'h313233343536373839, 8'hA1, 1'b1, 8'hA1};
      vt[3] = '{9'h107, 8'h00, 1'b0, 1'b0, 8'h00, 0, 128'h0,                   8'h00, 1'b1, 8'h00};
      vt[4] = '{9'h107, 8'h00, 1'b0, 1'b0, 8'h55, 9, 128'h313233343536373839, 8'hA1, 1'b1, 8'hA1};
      // Degree-4 polynomial: upper nibble of the CRC byte is ignored.
      vt[5] = '{9'h013, 8'h00, 1'b1, 1'b1, 8'h00, 9, 128'h313233343536373839, 8'hF7, 1'b1, 8'h07};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_m_data", m_data, 8'h00);
      chk("rst_st_valid", st_valid, 1'b0);
      chk("rst_st_ok", st_ok, 1'b0);
      chk("rst_st_crc", st_crc, 8'h00);
      chk("rst_st_len", st_len, 16'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", s_ready, 1'b1);
      @(posedge clk); #1;

      foreach (vt[i]) send_vec(vt[i], 1'b0);
      wait_drain();

      rdy_rand = 1'b1;
      foreach (vt[i]) send_vec(vt[i], 1'b1);
      wait_drain();

      for (int f = 0; f < 30; f++) begin
         v.poly = {1'b1, 8'($urandom) | 8'h01};
         v.init = 8'($urandom); v.xo = 8'($urandom);
         v.drev = 1'($urandom); v.crev = 1'($urandom);
         v.n    = $urandom_range(0, 14);
         v.pl   = {$urandom, $urandom, $urandom, $urandom};
         v.scrc = ref_crc(v);
         v.ok   = 1'($urandom);
         v.crc  = v.ok ? v.scrc : v.scrc ^ 8'($urandom_range(1, 255));
         rdy_rand = 1'($urandom);
         send_vec(v, 1'($urandom));
      end
      wait_drain();

      rdy_rand = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      poly_in = 9'h107; init_in = 8'h00; xorout_in = 8'h00;
      data_reverse = 1'b0; crc_reverse = 1'b0;
      exp_beats.push_back(9'h031); exp_beats.push_back(9'h032); exp_beats.push_back(9'h033);
      put(8'h31, 1'b0, 1'b0); put(8'h32, 1'b0, 1'b0);
      put(8'h33, 1'b0, 1'b0); put(8'h34, 1'b0, 1'b0);
      wait_drain();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready", s_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_m_valid", m_valid, 1'b0);
      chk("midrst_st_valid", st_valid, 1'b0);
      @(posedge clk); #1;
      send_vec(vt[0], 1'b0);
      wait_drain();
      repeat (4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
